alu_serial_seq: RTL and testbench
=================================

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, upstream operands valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have port op_a, input, WIDTH, first operand.
REQ-007 The block SHALL have port op_b, input, WIDTH, second operand.
REQ-008 The block SHALL have port op_sub, input, 1, 0 = add (a+b), 1 = subtract (a-b).
REQ-009 The block SHALL have port alu_a, output, 1, current operand-A bit driven to the external 1-bit ALU slice.
REQ-010 The block SHALL have port alu_b, output, 1, current operand-B bit driven to the slice (uninverted).
REQ-011 The block SHALL have port alu_opcode, output, 2, slice opcode {1'b0, latched op_sub}.
REQ-012 The block SHALL have port alu_cin, output, 1, carry-in driven to the slice.
REQ-013 The block SHALL have port alu_result, input, 1, combinational sum bit returned by the slice.
REQ-014 The block SHALL have port alu_cout, input, 1, combinational carry-out returned by the slice.
REQ-015 The block SHALL have port out_valid, output, 1, result available.
REQ-016 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-017 The block SHALL have port result, output, WIDTH, completed sum/difference.
REQ-018 The block SHALL have port carry_out, output, 1, final slice carry (for subtract: 1 = no borrow, a >= b unsigned).
REQ-019 The block SHALL have port overflow, output, 1, signed two's-complement overflow.
REQ-020 The block SHALL have port zero, output, 1, result == 0.

Function
REQ-021 The block SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-022 The block SHALL assert in_ready only in IDLE.
REQ-023 In IDLE, when in_valid=1, the block SHALL on that edge latch op_a, op_b and op_sub, clear the bit counter and carry register, and enter RUN.
REQ-024 In RUN, the block SHALL process bit k = counter value, LSB first, one bit per cycle.
REQ-025 For each RUN bit, the block SHALL drive alu_a = a[k] and alu_b = b[k].
REQ-026 For each RUN bit, the block SHALL drive alu_cin = latched op_sub when k = 0, else the carry register.
REQ-027 On each RUN edge, the block SHALL capture alu_result into result bit k and alu_cout into the carry register, then increment the counter.
REQ-028 On the RUN edge where k = WIDTH-1, the block SHALL set carry_out = alu_cout and overflow = alu_cin XOR alu_cout, and enter DONE.
REQ-029 Latency SHALL be exactly WIDTH+1 cycles from the accepting edge to the first cycle with out_valid = 1.
REQ-030 In DONE, the block SHALL hold out_valid = 1, with result, carry_out, overflow and zero stable, until out_ready = 1.
REQ-031 The DONE-to-IDLE transition SHALL occur on the edge where out_ready = 1; in_ready becomes 1 in the following cycle, with no overlap of accept and deliver.
REQ-032 Outside RUN, the block SHALL drive alu_a, alu_b and alu_cin to 0; alu_opcode SHALL hold the last latched value.
REQ-033 The zero output SHALL be derived combinationally from the result register.
REQ-034 Changes on op_a, op_b, op_sub or in_valid during RUN or DONE SHALL be ignored.
REQ-035 The block SHALL sample alu_result and alu_cout in the same cycle it drives the slice inputs, with no registered delay through the slice.

Reset
REQ-036 While rst_n = 0, the block SHALL immediately force state = IDLE, in_ready = 1, out_valid = 0, and result, carry_out, overflow, counter, carry register and latched operands to 0.
REQ-037 Reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse.
REQ-038 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-039 The bench SHALL apply WIDTH=8, add 0x05+0x03 and check result 0x08, carry_out 0, overflow 0, zero 0, with out_valid exactly 9 cycles after accept.
REQ-040 The bench SHALL apply add 0xFF+0x01 and check result 0x00, carry_out 1, overflow 0, zero 1.
REQ-041 The bench SHALL apply add 0x7F+0x01 and check result 0x80, carry_out 0, overflow 1.
REQ-042 The bench SHALL apply sub 0x10-0x20 and check result 0xF0, carry_out 0; then sub 0x20-0x20 and check result 0x00, carry_out 1, zero 1.
REQ-043 The bench SHALL hold out_ready = 0 for 5 cycles in DONE and check that outputs stay stable, in_ready stays 0 and in_valid is ignored; after out_ready = 1 for one cycle, in_ready = 1 on the next cycle.
REQ-044 The bench SHALL assert rst_n = 0 at bit 3 of a RUN and check that all outputs reach reset values at once, no out_valid appears, and a fresh add 0x01+0x01 completes with result 0x02.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial add/subtract sequencer: walks operands LSB-first through an external
// 1-bit ALU slice, rebuilding the result and flags in local registers.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_opcode,
  output logic             alu_cin,
  input  logic             alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             running;
  logic             last_bit;

  assign running  = (state_q == RUN);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The slice is purely combinational, so its answer for bit k is captured on this edge.
        res_d[cnt_q] = alu_result;
        carry_d      = alu_cout;
        cnt_d        = cnt_q + CW'(1);
        if (last_bit) begin
          cout_d  = alu_cout;
          ovf_d   = alu_cin ^ alu_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Subtraction relies on the slice inverting B and the initial carry of 1 forming two's complement.
  assign alu_a      = running ? a_q[cnt_q] : 1'b0;
  assign alu_b      = running ? b_q[cnt_q] : 1'b0;
  assign alu_cin    = running ? ((cnt_q == '0) ? sub_q : carry_q) : 1'b0;
  assign alu_opcode = {1'b0, sub_q};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq with a behavioural 1-bit add/sub slice model.
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             alu_a;
  logic             alu_b;
  logic [1:0]       alu_opcode;
  logic             alu_cin;
  logic             alu_result;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sub     (op_sub),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // External slice: opcode bit 0 selects subtract by inverting B.
  logic slice_b;
  always_comb begin
    slice_b    = alu_b ^ alu_opcode[0];
    alu_result = alu_a ^ slice_b ^ alu_cin;
    alu_cout   = (alu_a & slice_b) | (alu_a & alu_cin) | (slice_b & alu_cin);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    logic             z;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks every DONE cycle against the head of the scoreboard, pops on handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb[0];
        if (!prev_valid) chk("latency", 32'(cyc - e.acc), 32'(WIDTH + 1));
        chk("result", 32'(result), 32'(e.res));
        chk("carry_out", 32'(carry_out), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          $display("txn result=0x%02h carry=%0b ovf=%0b zero=%0b", result, carry_out, overflow, zero);
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  // Drives one operand set; returns just after the accepting edge (RUN bit 0 cycle).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                      input logic [WIDTH-1:0] r, input logic co, input logic ov, input logic z);
    exp_t e;
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    e.res = r; e.co = co; e.ov = ov; e.z = z; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = 8'hA5;
    op_b     = 8'h5A;
    op_sub   = ~sub;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0); drain();
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); drain();
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0); drain();
    send(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    chk("sub_cin_bit0", 32'(alu_cin), 32'd1);
    chk("sub_opcode", 32'(alu_opcode), 32'd1);
    drain();
    send(8'h20, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); drain();

    // Backpressure: hold DONE for 5 cycles while junk appears on the input side.
    out_ready = 1'b0;
    send(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("done_timeout", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op_a     = 8'(i * 37);
      op_b     = 8'(i + 9);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_done_in_ready", 32'(in_ready), 32'd1);
    chk("post_done_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Abort at bit 3 of a RUN.
    send(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_bit3_alu_a", 32'(alu_a), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0); drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
